fp32_adder: RTL and testbench

//   IEEE-754 binary32 adder: s = a + b, round-to-nearest-even, full subnormal support.

---
 rtl/fp32_pkg.sv | 32 +++
 rtl/fp32_lzc.sv | 22 ++
 rtl/fp32_adder.sv | 130 +++++++++++++
 tb/tb_fp32_adder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// +--------------------------------------------------------------------------+
// | fp32_pkg : binary32 field layout, constants and classification helpers   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package fp32_pkg;

  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic is_nan(input fp32_t f);
    return (f.exp == EXP_MAX) && (f.frac != '0);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (f.exp == EXP_MAX) && (f.frac == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_lzc.sv
// +--------------------------------------------------------------------------+
// | fp32_lzc : 28-bit leading-zero counter (all-zero input counts as 28)     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp32_lzc (
  input  logic [27:0] v_i,
  output logic [4:0]  cnt_o
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    cnt_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (v_i[i]) cnt_o = 5'(27 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_adder.sv
// +--------------------------------------------------------------------------+
// | fp32_adder : binary32 adder, round-to-nearest-even, one register stage.  |
// |   Define FP32_ADDER_FTZ_EN to flush subnormal inputs/results to zero.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp32_adder
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  fp32_t       fa, fb, fx, fy;
  logic        swap, sub;
  logic [7:0]  ex, ey, d;
  logic [23:0] mx, my;
  logic [26:0] my_ext, my_shr, my_al;
  logic        lost;
  logic [27:0] sum;
  logic [4:0]  lz, sh_raw;
  logic [7:0]  sh;
  logic [26:0] m;
  logic [9:0]  e, e_out;
  logic        inc;
  logic [24:0] mr;
  logic [22:0] frac_out;
  logic [31:0] s_d, s_q;

  assign fa   = a;
  assign fb   = b;
  assign swap = (b[30:0] > a[30:0]);
  assign fx   = swap ? fb : fa;
  assign fy   = swap ? fa : fb;
  assign sub  = fx.sign ^ fy.sign;

  // Subnormals use effective exponent 1 so they align against normals directly.
  assign ex = (fx.exp == 8'd0) ? 8'd1 : fx.exp;
  assign ey = (fy.exp == 8'd0) ? 8'd1 : fy.exp;
`ifdef FP32_ADDER_FTZ_EN
  assign mx = (fx.exp == 8'd0) ? 24'd0 : {1'b1, fx.frac};
  assign my = (fy.exp == 8'd0) ? 24'd0 : {1'b1, fy.frac};
`else
  assign mx = {fx.exp != 8'd0, fx.frac};
  assign my = {fy.exp != 8'd0, fy.frac};
`endif

  assign d      = ex - ey;
  assign my_ext = {my, 3'b000};
  assign my_shr = my_ext >> d;
  assign lost   = |(my_ext & ((27'd1 << d) - 27'd1));
  assign my_al  = (d >= 8'd27) ? {26'd0, |my} : {my_shr[26:1], my_shr[0] | lost};

  assign sum = sub ? ({1'b0, mx, 3'b000} - {1'b0, my_al})
                   : ({1'b0, mx, 3'b000} + {1'b0, my_al});

  fp32_lzc u_lzc (
    .v_i   (sum),
    .cnt_o (lz)
  );

  assign sh_raw = lz - 5'd1;

  always_comb begin
    m  = '0;
    e  = '0;
    sh = '0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = {2'b00, ex} + 10'd1;
    end else begin
`ifdef FP32_ADDER_FTZ_EN
      sh = {3'b000, sh_raw};
`else
      // Never normalise below exponent 1; anything left unnormalised is subnormal.
      sh = ({3'b000, sh_raw} > (ex - 8'd1)) ? (ex - 8'd1) : {3'b000, sh_raw};
`endif
      m = sum[26:0] << sh;
      e = {2'b00, ex} - {2'b00, sh};
    end
  end

  assign inc = m[2] & (m[1] | m[0] | m[3]);
  assign mr  = {1'b0, m[26:3]} + {24'd0, inc};

  always_comb begin
    if (mr[24]) begin
      e_out    = e + 10'd1;
      frac_out = mr[23:1];
    end else begin
      e_out    = mr[23] ? e : 10'd0;
      frac_out = mr[22:0];
    end
  end

  always_comb begin
    s_d = POS_ZERO;
    if (is_nan(fa) || is_nan(fb) || (is_inf(fa) && is_inf(fb) && (fa.sign != fb.sign))) begin
      s_d = QNAN;
    end else if (is_inf(fa)) begin
      s_d = a;
    end else if (is_inf(fb)) begin
      s_d = b;
    end else if (sum == 28'd0) begin
      s_d = {~sub & fx.sign, 31'd0};
`ifdef FP32_ADDER_FTZ_EN
    end else if (e[9] || (e_out == 10'd0)) begin
      s_d = {fx.sign, 31'd0};
`endif
    end else if (e_out >= 10'd255) begin
      s_d = {fx.sign, EXP_MAX, 23'd0};
    end else begin
      s_d = {fx.sign, e_out[7:0], frac_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= POS_ZERO;
    else     s_q <= s_d;
  end

  assign s = s_q;

endmodule

`default_nettype wire

// File: tb/tb_fp32_adder.sv
// +--------------------------------------------------------------------------+
// | tb_fp32_adder : directed and randomised checks of fp32_adder             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = 32'd0;
  logic [31:0] b   = 32'd0;
  logic [31:0] s;
  int          checks = 0;
  int          passed = 0;

  fp32_adder dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .s   (s)
  );

  always #5 clk = ~clk;

  function automatic real real_of_f32(input logic [31:0] f);
    real v;
    if (f[30:23] == 8'd0) v = real'(f[22:0]) * (2.0 ** real'(-149));
    else                  v = real'({1'b1, f[22:0]}) * (2.0 ** real'(int'(f[30:23]) - 150));
    return f[31] ? -v : v;
  endfunction

  // Round a double to binary32 with round-to-nearest-even.
  function automatic logic [31:0] f32_of_real(input real r);
    logic [63:0] dbits, sig, kept, rem, half;
    int          fe, sh;
    dbits = $realtobits(r);
    if (dbits[62:0] == 63'd0) return {dbits[63], 31'd0};
    fe   = int'(dbits[62:52]) - 896;
    sig  = {11'd0, 1'b1, dbits[51:0]};
    sh   = 29 + ((fe < 1) ? (1 - fe) : 0);
    if (sh > 60) sh = 60;
    kept = sig >> sh;
    rem  = sig & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 64'd1;
    if (fe < 1) return {dbits[63], (kept[23] ? 8'd1 : 8'd0), kept[22:0]};
    if (kept[24]) begin
      fe   = fe + 1;
      kept = kept >> 1;
    end
    if (fe >= 255) return {dbits[63], 8'hFF, 23'd0};
    return {dbits[63], 8'(fe), kept[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: s=%h expected %h", tag, obs, want);
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] want, input string tag);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, s, want);
  endtask

  initial begin
    logic [31:0] x, y, w;

    #12;
    check("reset", s, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // One-cycle latency: nothing visible before the edge.
    @(negedge clk);
    a = 32'h3F80_0000;
    b = 32'h3F80_0000;
    #1;
    check("no_early", s, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("one_plus_one", s, 32'h4000_0000);

    run(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "cancel_pos0");
    run(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, "rne_tie_even");
    run(32'h4B80_0000, 32'h4000_0000, 32'h4B80_0001, "rne_lsb");
    run(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_down");
    run(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "sticky_up");
    run(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, "three_minus_one");
    run(32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, "massive_cancel");
    run(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow_inf");
    run(32'h7F7F_FFFF, 32'h7300_0000, 32'h7F80_0000, "round_to_inf");
    run(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    run(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_a");
    run(32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, "nan_b");
    run(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "neg_inf_finite");
    run(32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, "inf_plus_inf");
    run(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "neg0_neg0");
    run(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, "pos0_neg0");
    run(32'h0080_0000, 32'h8080_0000, 32'h0000_0000, "minnorm_cancel");
`ifdef FP32_ADDER_FTZ_EN
    run(32'h0000_0001, 32'h0000_0001, 32'h0000_0000, "sub_plus_sub");
    run(32'h007F_FFFF, 32'h0000_0001, 32'h0000_0000, "sub_to_norm");
    run(32'h0080_0000, 32'h8000_0001, 32'h0080_0000, "norm_to_sub");
`else
    run(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, "sub_plus_sub");
    run(32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000, "sub_to_norm");
    run(32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, "norm_to_sub");
`endif

    // Asynchronous reset mid-stream, then resume.
    run(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "pre_reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", s, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_hold", s, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_resume", s, 32'h4000_0000);

    for (int i = 0; i < 4000; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 2 == 1) y[30:23] = x[30:23] - 8'($urandom_range(0, 3));
      if (i % 8 == 0) begin
        x[30:23] = 8'd0;
        y[30:23] = 8'($urandom_range(0, 1));
      end
      w = f32_of_real(real_of_f32(x) + real_of_f32(y));
      if (x[30:23] == 8'hFF || y[30:23] == 8'hFF || w[30:23] == 8'hFF) continue;
`ifdef FP32_ADDER_FTZ_EN
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || w[30:23] <= 8'd1) continue;
`endif
      run(x, y, w, "random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
